// File: rtl/adc_tx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : adc_tx_pattern_gen
// Brief    : ADC-side transmit pattern generator. Brings a serial link up
//            through a lock-settle wait and a training phase, then emits ramp,
//            PRBS7 or fixed data on LANES parallel 8-bit lanes plus a frame lane.
// Revision : 1.0 - initial release
// ============================================================================
module adc_tx_pattern_gen #(
  parameter int         LANES      = 4,
  parameter logic [7:0] TRAIN_WORD = 8'hF0,
  parameter int         LOCK_WAIT  = 512,
  parameter int         ALIGN_HOLD = 16
) (
  input  logic                 clk_div_a,
  input  logic                 sys_rst_n,
  input  logic                 tx_en,
  input  logic [1:0]           mode,
  input  logic [7:0]           fixed_word,
  input  logic                 rx_aligned,
  output logic [7:0]           frame_out,
  output logic [LANES*8-1:0]   data_out,
  output logic                 tx_valid,
  output logic                 tx_locked,
  output logic [1:0]           state_out
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_TRAIN     = 2'd2,
    ST_DATA      = 2'd3
  } state_t;

  localparam int                  C_HOLD_W    = (ALIGN_HOLD > 1) ? $clog2(ALIGN_HOLD) : 1;
  localparam logic [6:0]          C_PRBS_SEED = 7'h7F;
  localparam logic [9:0]          C_LOCK_LAST = 10'(LOCK_WAIT - 1);
  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(ALIGN_HOLD - 1);
  localparam logic [7:0]          C_LANE_STEP = 8'(LANES);

  // Control and generator state
  state_t                state_q;
  logic [9:0]            lock_cnt_q;
  logic [C_HOLD_W-1:0]   hold_cnt_q;
  logic                  locked_q;
  logic [7:0]            base_q;
  logic [6:0]            prbs_q;

  // Next values for the registered port stage
  logic [6:0]            prbs_adv_d;
  logic [7:0]            prbs_byte_d;
  logic [LANES*8-1:0]    payload_d;
  logic [7:0]            frame_d;
  logic [LANES*8-1:0]    data_d;
  logic                  valid_d;

  // Registered port copies
  logic [7:0]            frame_q;
  logic [LANES*8-1:0]    data_q;
  logic                  valid_q;
  logic                  tx_locked_q;
  logic [1:0]            state_out_q;

  // PRBS7 (x^7+x^6+1) stepped 8 bits; first generated bit lands in the MSB
  always_comb begin
    prbs_adv_d  = prbs_q;
    prbs_byte_d = '0;
    for (int b = 7; b >= 0; b--) begin
      prbs_byte_d[b] = prbs_adv_d[6] ^ prbs_adv_d[5];
      prbs_adv_d     = {prbs_adv_d[5:0], prbs_byte_d[b]};
    end
    // An all-zero register would lock the LFSR up; recover to the seed
    if (prbs_q == '0) begin
      prbs_adv_d = C_PRBS_SEED;
    end
  end

  // Mode-selected lane payload; modes 0 and 3 are both ramp
  always_comb begin
    payload_d = '0;
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        2'd1:    payload_d[8*i +: 8] = prbs_byte_d;
        2'd2:    payload_d[8*i +: 8] = fixed_word;
        default: payload_d[8*i +: 8] = base_q + 8'(i);
      endcase
    end
  end

  // Port values implied by the current state, captured one cycle later
  always_comb begin
    frame_d = '0;
    data_d  = '0;
    valid_d = 1'b0;
    case (state_q)
      ST_TRAIN: begin
        frame_d = TRAIN_WORD;
        data_d  = {LANES{TRAIN_WORD}};
      end
      ST_DATA: begin
        frame_d = TRAIN_WORD;
        data_d  = payload_d;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Link bring-up FSM with lock/hold counters and the pattern generators
  always_ff @(posedge clk_div_a or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      locked_q   <= 1'b0;
      base_q     <= '0;
      prbs_q     <= C_PRBS_SEED;
    end else if (!tx_en) begin
      // Disable wins over every other transition and ends the session
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      locked_q   <= 1'b0;
      base_q     <= '0;
      prbs_q     <= C_PRBS_SEED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_WAIT_LOCK;
          lock_cnt_q <= '0;
        end
        ST_WAIT_LOCK: begin
          lock_cnt_q <= lock_cnt_q + 1'b1;
          if (lock_cnt_q == C_LOCK_LAST) begin
            state_q    <= ST_TRAIN;
            locked_q   <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        ST_TRAIN: begin
          if (!rx_aligned) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == C_HOLD_LAST) begin
            // Fresh generators so the first DATA word is deterministic
            state_q    <= ST_DATA;
            hold_cnt_q <= '0;
            base_q     <= '0;
            prbs_q     <= C_PRBS_SEED;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          // Both generators run regardless of mode so a mode switch resumes mid-stream
          base_q <= base_q + C_LANE_STEP;
          prbs_q <= prbs_adv_d;
          if (!rx_aligned) begin
            state_q    <= ST_TRAIN;
            hold_cnt_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk_div_a or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      tx_locked_q <= 1'b0;
      state_out_q <= 2'd0;
    end else begin
      frame_q     <= frame_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      tx_locked_q <= locked_q;
      state_out_q <= state_q;
    end
  end

  assign frame_out = frame_q;
  assign data_out  = data_q;
  assign tx_valid  = valid_q;
  assign tx_locked = tx_locked_q;
  assign state_out = state_out_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_tx_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_adc_tx_pattern_gen
// Brief    : Directed self-checking bench for adc_tx_pattern_gen (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_tx_pattern_gen;

  logic        clk_div_a  = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        tx_en      = 1'b0;
  logic [1:0]  mode       = 2'd0;
  logic [7:0]  fixed_word = 8'h00;
  logic        rx_aligned = 1'b0;
  logic [7:0]  frame_out;
  logic [31:0] data_out;
  logic        tx_valid;
  logic        tx_locked;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  // PRBS7 reference bit stream: b[n] = b[n-7] ^ b[n-6], seven leading ones as seed
  logic ref_bits [0:1199];

  always #5 clk_div_a = ~clk_div_a;

  adc_tx_pattern_gen dut (
    .clk_div_a  (clk_div_a),
    .sys_rst_n  (sys_rst_n),
    .tx_en      (tx_en),
    .mode       (mode),
    .fixed_word (fixed_word),
    .rx_aligned (rx_aligned),
    .frame_out  (frame_out),
    .data_out   (data_out),
    .tx_valid   (tx_valid),
    .tx_locked  (tx_locked),
    .state_out  (state_out)
  );

  task automatic tick;
    @(posedge clk_div_a);
    #1;
  endtask

  function automatic logic [7:0] ref_byte(input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[7-j] = ref_bits[7 + 8*k + j];
    return r;
  endfunction

  task automatic build_prbs_ref;
    for (int n = 0; n < 7; n++) ref_bits[n] = 1'b1;
    for (int n = 7; n < 1200; n++) ref_bits[n] = ref_bits[n-7] ^ ref_bits[n-6];
  endtask

  task automatic wait_for_state(input logic [1:0] s, input int bound, input string tag);
    int n = 0;
    while (state_out !== s && n < bound) begin
      tick;
      n++;
    end
    checks++;
    if (state_out !== s) begin
      errors++;
      $display("FAIL %s: state_out=%0d expected %0d within %0d cycles", tag, state_out, s, bound);
    end
  endtask

  task automatic measure_lock(input string tag);
    int n = 0;
    int guard = 0;
    while (state_out !== 2'd1 && guard < 8) begin
      tick;
      guard++;
    end
    checks++;
    if (tx_locked !== 1'b0 || data_out !== 32'h0 || frame_out !== 8'h00) begin
      errors++;
      $display("FAIL %s_wait_outputs: locked=%b data=%h frame=%h expected 0/0/0", tag, tx_locked, data_out, frame_out);
    end
    while (state_out === 2'd1 && n < 600) begin
      n++;
      tick;
    end
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL %s_wait_len: state_out=1 for %0d cycles expected 512", tag, n);
    end
    checks++;
    if (state_out !== 2'd2 || tx_locked !== 1'b1) begin
      errors++;
      $display("FAIL %s_lock: state_out=%0d tx_locked=%b expected 2/1", tag, state_out, tx_locked);
    end
    tick;
    checks++;
    if (data_out !== 32'hF0F0F0F0 || frame_out !== 8'hF0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_train_words: data=%h frame=%h valid=%b expected f0f0f0f0/f0/0", tag, data_out, frame_out, tx_valid);
    end
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++;
    if (state_out !== 2'd0 || data_out !== 32'h0 || frame_out !== 8'h0 || tx_valid !== 1'b0 || tx_locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: st=%0d data=%h frame=%h valid=%b locked=%b expected all 0", state_out, data_out, frame_out, tx_valid, tx_locked);
    end
    tx_en = 1'b1;
    tick;
    tick;
    checks++;
    if (state_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold: state_out=%0d expected 0 while reset held", state_out);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_lock_wait;
    measure_lock("lock");
  endtask

  task automatic test_train_align;
    int bad = 0;
    mode = 2'd0;
    for (int i = 0; i < 32; i++) begin
      rx_aligned = (i != 15);
      tick;
      if (state_out !== 2'd2 || tx_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL train_hold: %0d samples left TRAIN early, expected 0", bad);
    end
    tick;
    checks++;
    if (state_out !== 2'd3 || tx_valid !== 1'b1 || frame_out !== 8'hF0) begin
      errors++;
      $display("FAIL data_entry: st=%0d valid=%b frame=%h expected 3/1/f0", state_out, tx_valid, frame_out);
    end
    checks++;
    if (data_out !== 32'h03020100) begin
      errors++;
      $display("FAIL ramp_first: data=%h expected 03020100", data_out);
    end
  endtask

  task automatic test_ramp;
    int bad = 0;
    logic [31:0] exp;
    for (int k = 1; k < 70; k++) begin
      tick;
      for (int i = 0; i < 4; i++) exp[8*i +: 8] = 8'(4*k + i);
      if (data_out !== exp || tx_valid !== 1'b1) bad++;
      if (k == 1) begin
        checks++;
        if (data_out !== 32'h07060504) begin
          errors++;
          $display("FAIL ramp_second: data=%h expected 07060504", data_out);
        end
      end
      if (k == 63) begin
        checks++;
        if (data_out !== 32'hFFFEFDFC) begin
          errors++;
          $display("FAIL ramp_top: data=%h expected fffefdfc", data_out);
        end
      end
      if (k == 64) begin
        checks++;
        if (data_out !== 32'h03020100) begin
          errors++;
          $display("FAIL ramp_wrap: data=%h expected 03020100", data_out);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ramp_seq: %0d words wrong, expected 0", bad);
    end
  endtask

  task automatic test_align_drop;
    rx_aligned = 1'b0;
    tick;
    tick;
    checks++;
    if (state_out !== 2'd2 || tx_valid !== 1'b0 || data_out !== 32'hF0F0F0F0 || frame_out !== 8'hF0) begin
      errors++;
      $display("FAIL align_drop: st=%0d valid=%b data=%h frame=%h expected 2/0/f0f0f0f0/f0", state_out, tx_valid, data_out, frame_out);
    end
  endtask

  task automatic test_prbs;
    int bad = 0;
    mode = 2'd1;
    rx_aligned = 1'b1;
    wait_for_state(2'd3, 40, "prbs_entry");
    checks++;
    if (data_out !== 32'h02020202) begin
      errors++;
      $display("FAIL prbs_w0: data=%h expected 02020202", data_out);
    end
    for (int k = 1; k < 130; k++) begin
      tick;
      if (data_out !== {4{ref_byte(k)}}) bad++;
      if (k == 1 || k == 128) begin
        checks++;
        if (data_out !== 32'h0C0C0C0C) begin
          errors++;
          $display("FAIL prbs_w%0d: data=%h expected 0c0c0c0c", k, data_out);
        end
      end
      if (k == 2) begin
        checks++;
        if (data_out !== 32'h28282828) begin
          errors++;
          $display("FAIL prbs_w2: data=%h expected 28282828", data_out);
        end
      end
      if (k == 127) begin
        checks++;
        if (data_out !== 32'h02020202) begin
          errors++;
          $display("FAIL prbs_period: data=%h expected 02020202", data_out);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL prbs_seq: %0d words differ from reference, expected 0", bad);
    end
  endtask

  task automatic test_mode_switch;
    mode = 2'd2;
    fixed_word = 8'hA5;
    tick;
    checks++;
    if (data_out !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL fixed_a5: data=%h expected a5a5a5a5", data_out);
    end
    fixed_word = 8'h3C;
    tick;
    checks++;
    if (data_out !== 32'h3C3C3C3C) begin
      errors++;
      $display("FAIL fixed_3c: data=%h expected 3c3c3c3c", data_out);
    end
    mode = 2'd0;
    tick;
    checks++;
    if (data_out !== 32'h13121110) begin
      errors++;
      $display("FAIL switch_ramp: data=%h expected 13121110", data_out);
    end
    mode = 2'd1;
    tick;
    checks++;
    if (data_out !== {4{ref_byte(133)}} || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL switch_prbs: data=%h valid=%b expected %h/1", data_out, tx_valid, {4{ref_byte(133)}});
    end
  endtask

  task automatic test_disable_and_reset;
    tx_en = 1'b0;
    tick;
    tick;
    checks++;
    if (state_out !== 2'd0 || data_out !== 32'h0 || frame_out !== 8'h0 || tx_valid !== 1'b0 || tx_locked !== 1'b0) begin
      errors++;
      $display("FAIL disable: st=%0d data=%h frame=%h valid=%b locked=%b expected all 0", state_out, data_out, frame_out, tx_valid, tx_locked);
    end
    tx_en = 1'b1;
    for (int i = 0; i < 20; i++) tick;
    checks++;
    if (state_out !== 2'd1 || tx_locked !== 1'b0) begin
      errors++;
      $display("FAIL relock_start: st=%0d locked=%b expected 1/0", state_out, tx_locked);
    end
    #3 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (state_out !== 2'd0 || tx_locked !== 1'b0 || data_out !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_wait: st=%0d locked=%b data=%h expected 0/0/0", state_out, tx_locked, data_out);
    end
    tick;
    sys_rst_n = 1'b1;
    measure_lock("resume");
    wait_for_state(2'd3, 40, "resume_data");
    checks++;
    if (data_out !== 32'h02020202) begin
      errors++;
      $display("FAIL resume_prbs: data=%h expected 02020202", data_out);
    end
    #3 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (state_out !== 2'd0 || data_out !== 32'h0 || frame_out !== 8'h0 || tx_valid !== 1'b0 || tx_locked !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_data: st=%0d data=%h frame=%h valid=%b locked=%b expected all 0", state_out, data_out, frame_out, tx_valid, tx_locked);
    end
    tick;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    build_prbs_ref();
    test_reset();
    test_lock_wait();
    test_train_align();
    test_ramp();
    test_align_drop();
    test_prbs();
    test_mode_switch();
    test_disable_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/adc_tx_pattern_gen.md
ADC_TX_PATTERN_GEN -- requirements
Module: adc_tx_pattern_gen

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning number of 8-bit data lanes driven per clock.
REQ-002 The block SHALL have parameter TRAIN_WORD, default 8'hF0, meaning the training/frame word.
REQ-003 The block SHALL have parameter LOCK_WAIT, default 512, meaning settle cycles before training starts.
REQ-004 The block SHALL have parameter ALIGN_HOLD, default 16, meaning consecutive rx_aligned cycles needed to leave training.
REQ-005 The block SHALL have clk_div_a  input  1  single clock (156.25 MHz divided ADC-rate clock); every register SHALL be clocked on its rising edge.
REQ-006 The block SHALL have sys_rst_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have tx_en  input  1  enables transmission.
REQ-008 The block SHALL have mode  input  2  data source select: 0 ramp, 1 PRBS7, 2 fixed, 3 ramp.
REQ-009 The block SHALL have fixed_word  input  8  word used in mode 2.
REQ-010 The block SHALL have rx_aligned  input  1  alignment status from the far-end receiver, synchronous to clk_div_a.
REQ-011 The block SHALL have frame_out  output  8  frame-lane parallel word, for the 8:1 serializer.
REQ-012 The block SHALL have data_out  output  LANES*8  data-lane parallel words; lane i occupies bits [8i+7:8i].
REQ-013 The block SHALL have tx_valid  output  1  high only in DATA state.
REQ-014 The block SHALL have tx_locked  output  1  high once LOCK_WAIT has elapsed in the current enable session.
REQ-015 The block SHALL have state_out  output  2  current state encoding: IDLE=0, WAIT_LOCK=1, TRAIN=2, DATA=3.

Function
REQ-016 All outputs SHALL be registered, with one cycle of latency from state/generator update to port.
REQ-017 IDLE: outputs SHALL be zero; when tx_en=1 the next state SHALL be WAIT_LOCK with the lock counter at 0.
REQ-018 WAIT_LOCK: the 10-bit counter SHALL increment each cycle, outputs SHALL stay zero, and on count = LOCK_WAIT-1 the next state SHALL be TRAIN with tx_locked set.
REQ-019 TRAIN: frame_out and every data lane SHALL equal TRAIN_WORD, and the hold counter SHALL increment while rx_aligned=1 and clear to 0 when rx_aligned=0.
REQ-020 TRAIN exit: when the hold counter reaches ALIGN_HOLD-1 with rx_aligned=1, the next state SHALL be DATA.
REQ-021 DATA: frame_out SHALL equal TRAIN_WORD, tx_valid SHALL be 1, and data_out SHALL carry the mode-selected pattern.
REQ-022 Ramp: with base an 8-bit register, lane i SHALL be base+i (mod 256), and base SHALL advance by LANES per DATA cycle with wrap at 256.
REQ-023 PRBS7: the generator SHALL use x^7+x^6+1 with seed 7'h7F and advance 8 bits per DATA cycle, with all lanes carrying the same 8 output bits, MSB first.
REQ-024 Fixed: all lanes SHALL equal fixed_word, sampled each cycle.
REQ-025 On entry to DATA, base SHALL be 0 and PRBS SHALL be reseeded, so the first DATA word in ramp mode is lane i = i.
REQ-026 A mode change during DATA SHALL take effect on the next cycle without reseeding or clearing base.
REQ-027 rx_aligned=0 during DATA SHALL cause a transition to TRAIN next cycle, with tx_valid low and the hold counter cleared.
REQ-028 tx_en=0 in any state SHALL cause a transition to IDLE next cycle, clearing tx_locked and all counters; tx_en has priority over every other transition.
REQ-029 A PRBS state of all-zeros SHALL never occur; if detected, the generator SHALL reload 7'h7F.

Reset
REQ-030 With sys_rst_n=0 the block SHALL asynchronously force state IDLE, all counters, base and outputs to 0, tx_locked to 0, and PRBS to 7'h7F.
REQ-031 Reset assertion mid-operation SHALL abort immediately with no partial words; after release the block SHALL resume from IDLE.

Verification
REQ-032 The bench SHALL cover: reset, then tx_en=1 at cycle 0 -> state_out=1 for 512 cycles, tx_locked rises with state_out=2, data_out=all 8'hF0.
REQ-033 The bench SHALL cover: in TRAIN, rx_aligned high 15 cycles, low 1, high 16 -> DATA entered only after the final 16-cycle run; tx_valid rises 1 cycle later.
REQ-034 The bench SHALL cover: DATA with mode=0, LANES=4 -> words {3,2,1,0}, {7,6,5,4} ..., with base wrapping 252->0 (lanes 252..255 then 0..3).
REQ-035 The bench SHALL cover: DATA with mode=1 -> the first 16 output bits match a reference x^7+x^6+1 model seeded 7'h7F; PRBS period is 127 bits.
REQ-036 The bench SHALL cover: rx_aligned dropped in DATA -> next cycle state_out=2, tx_valid=0, lanes=8'hF0.
REQ-037 The bench SHALL cover: tx_en deasserted in DATA, then sys_rst_n pulsed mid-WAIT_LOCK -> IDLE, outputs zero, tx_locked=0 within 1 cycle (async for reset).
